// File: rtl/dii_package.sv
`default_nettype none
// ============================================================================
// Package     : dii_package
// Description : Shared types and constants for the DII debug ring: the flit
//               structure, event packet type/subtype codes, the state
//               encodings of the UART terminal bridge FSMs and a saturating
//               counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dii_package;

    // One ring flit: handshake valid, end-of-packet marker, 16-bit payload.
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    localparam logic [1:0] DII_TYPE_EVENT     = 2'b10;
    localparam logic [3:0] DII_SUB_EVENT_LAST = 4'b0000;

    // Flags word carried in flit 2 of every UART character event.
    localparam logic [15:0] UART_EVENT_FLAGS = {DII_TYPE_EVENT, DII_SUB_EVENT_LAST, 10'h000};

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_DEST  = 3'd1,
        TX_SRC   = 3'd2,
        TX_FLAGS = 3'd3,
        TX_DATA  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_HDR_DEST  = 3'd0,
        RX_HDR_SRC   = 3'd1,
        RX_HDR_FLAGS = 3'd2,
        RX_DATA      = 3'd3,
        RX_DISCARD   = 3'd4
    } rx_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osd_uart_term_fifo.sv
`default_nettype none
// ============================================================================
// Module      : osd_uart_term_fifo
// Description : Synchronous single-clock FIFO holding received characters.
//               A push is ignored while full and a pop is ignored while
//               empty; both gates use the current-cycle flags, so a full
//               FIFO never accepts a push in the cycle it is popped.
// Ports       : clk, rst        clock, synchronous active-high reset
//               push, push_data write request and data
//               pop, pop_data   read request and head-of-queue data
//               full, empty     occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module osd_uart_term_fifo #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign full     = (r_count == CNT_FULL);
    assign empty    = (r_count == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/osd_uart_term_bridge.sv
`default_nettype none
// ============================================================================
// Module      : osd_uart_term_bridge
// Description : Host-side terminal endpoint for the DEM-UART character
//               channel on the DII debug ring. Received single-character
//               event packets are validated and their payload queued in a
//               FIFO; host characters are wrapped into 4-flit event packets
//               addressed to the target UART module.
// Ports       : clk, rst                   clock, synchronous active-high reset
//               debug_in / debug_in_ready   flits from the ring
//               debug_out / debug_out_ready flits to the ring
//               id, target_id              own address, target UART address
//               rx_char/rx_valid/rx_ready  received character stream
//               tx_char/tx_valid/tx_ready  host character stream
//               err_cnt                    saturating discarded-packet count
// Config      : OSD_UART_TERM_SRC_FILTER_EN - when defined, packets whose
//               source is not target_id are discarded and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_uart_term_bridge
    import dii_package::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  dii_flit     debug_in,
    output logic        debug_in_ready,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    input  logic [15:0] id,
    input  logic [15:0] target_id,
    output logic [7:0]  rx_char,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_char,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  err_cnt
);

    // ------------------------------------------------------------------
    // TX path: one character in flight, flits produced from registers.
    // ------------------------------------------------------------------
    tx_state_t   r_tx_state;
    dii_flit     r_out;
    logic        r_tx_ready;
    logic [7:0]  r_tx_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_out      <= '0;
            r_tx_ready <= 1'b1;
            r_tx_buf   <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        r_tx_buf   <= tx_char;
                        r_out      <= '{valid: 1'b1, last: 1'b0, data: target_id};
                        r_tx_ready <= 1'b0;
                        r_tx_state <= TX_DEST;
                    end
                end
                TX_DEST: begin
                    if (debug_out_ready) begin
                        r_out.data <= id;
                        r_tx_state <= TX_SRC;
                    end
                end
                TX_SRC: begin
                    if (debug_out_ready) begin
                        r_out.data <= UART_EVENT_FLAGS;
                        r_tx_state <= TX_FLAGS;
                    end
                end
                TX_FLAGS: begin
                    if (debug_out_ready) begin
                        r_out.data <= {8'h00, r_tx_buf};
                        r_out.last <= 1'b1;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (debug_out_ready) begin
                        r_out      <= '0;
                        r_tx_ready <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_out      <= '0;
                    r_tx_ready <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign debug_out = r_out;
    assign tx_ready  = r_tx_ready;

    // ------------------------------------------------------------------
    // RX path: header validation, payload into the char FIFO.
    // ------------------------------------------------------------------
    rx_state_t   r_rx_state;
    logic [7:0]  r_err_cnt;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_data;
    logic        w_in_acc;
    logic        w_push;
    logic        w_flags_ok;

    // Only the DATA flit can be stalled; header and discarded flits are
    // always consumed so the ring never blocks on a rejected packet.
    assign debug_in_ready = (r_rx_state == RX_DATA) ? !w_fifo_full : 1'b1;
    assign w_in_acc       = debug_in.valid && debug_in_ready;
    assign w_push         = w_in_acc && (r_rx_state == RX_DATA);
    assign w_flags_ok     = (debug_in.data[15:14] == DII_TYPE_EVENT) &&
                            (debug_in.data[13:10] == DII_SUB_EVENT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_HDR_DEST;
            r_err_cnt  <= '0;
        end else if (w_in_acc) begin
            case (r_rx_state)
                RX_HDR_DEST: begin
                    if (debug_in.last) begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                    end else if (debug_in.data != id) begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_rx_state <= RX_DISCARD;
                    end else begin
                        r_rx_state <= RX_HDR_SRC;
                    end
                end
                RX_HDR_SRC: begin
                    if (debug_in.last) begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_rx_state <= RX_HDR_DEST;
                    end
`ifdef OSD_UART_TERM_SRC_FILTER_EN
                    else if (debug_in.data != target_id) begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_rx_state <= RX_DISCARD;
                    end
`endif
                    else begin
                        r_rx_state <= RX_HDR_FLAGS;
                    end
                end
                RX_HDR_FLAGS: begin
                    if (debug_in.last) begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_rx_state <= RX_HDR_DEST;
                    end else if (!w_flags_ok) begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_rx_state <= RX_DISCARD;
                    end else begin
                        r_rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    // The char is kept even when the packet overruns; the
                    // trailing flits are dropped and the packet counted.
                    if (debug_in.last) begin
                        r_rx_state <= RX_HDR_DEST;
                    end else begin
                        r_err_cnt  <= sat_inc8(r_err_cnt);
                        r_rx_state <= RX_DISCARD;
                    end
                end
                RX_DISCARD: begin
                    if (debug_in.last) begin
                        r_rx_state <= RX_HDR_DEST;
                    end
                end
                default: r_rx_state <= RX_HDR_DEST;
            endcase
        end
    end

    osd_uart_term_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (debug_in.data[7:0]),
        .pop       (rx_ready),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign rx_valid = !w_fifo_empty;
    assign rx_char  = w_fifo_empty ? 8'h00 : w_fifo_data;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_osd_uart_term_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_uart_term_bridge
// Description : Self-checking bench for osd_uart_term_bridge. Directed
//               scenarios plus randomized TX/RX traffic compared against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_uart_term_bridge;
    import dii_package::*;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    dii_flit     debug_in;
    logic        debug_in_ready;
    dii_flit     debug_out;
    logic        debug_out_ready;
    logic [15:0] id;
    logic [15:0] target_id;
    logic [7:0]  rx_char;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_char;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  err_cnt;

    int          checks = 0;
    int          errors = 0;
    bit          src_filter;
    logic [15:0] pkt [8];
    logic [7:0]  exp_q [$];
    int          exp_err;
    bit          rnd_done;

    always #5 clk = ~clk;

    osd_uart_term_bridge #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .debug_in        (debug_in),
        .debug_in_ready  (debug_in_ready),
        .debug_out       (debug_out),
        .debug_out_ready (debug_out_ready),
        .id              (id),
        .target_id       (target_id),
        .rx_char         (rx_char),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .tx_char         (tx_char),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .err_cnt         (err_cnt)
    );

    initial begin
        #800000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // Packet-level outcome: does a char get delivered, and is the packet
    // counted as an error.
    function automatic void model_pkt(input logic [15:0] fl [8], input int n,
                                      output bit has_char, output logic [7:0] ch,
                                      output bit err);
        has_char = 1'b0;
        ch       = 8'h00;
        err      = 1'b1;
        if (n < 2) return;
        if (fl[0] != id) return;
        if (n < 3) return;
        if (src_filter && fl[1] != target_id) return;
        if (n < 4) return;
        if (fl[2][15:14] != 2'b10 || fl[2][13:10] != 4'h0) return;
        has_char = 1'b1;
        ch       = fl[3][7:0];
        err      = (n > 4);
    endfunction

    task automatic drive_flit(input logic lst, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        debug_in.valid = 1'b1;
        debug_in.last  = lst;
        debug_in.data  = d;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (debug_in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flit_accept ready=%0b required=1", debug_in_ready);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            drive_flit(i == n - 1, pkt[i]);
        end
        @(negedge clk);
        debug_in = '0;
    endtask

    task automatic set_good(input logic [7:0] ch);
        pkt[0] = id;
        pkt[1] = target_id;
        pkt[2] = 16'h8000;
        pkt[3] = {8'h00, ch};
    endtask

    task automatic pop_check(input logic [7:0] e, input string name);
        @(negedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_char !== e) begin
            errors++;
            $display("FAIL %s rx_valid=%0b rx_char=%02h required valid=1 char=%02h",
                     name, rx_valid, rx_char, e);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic check_err(input logic [7:0] e, input string name);
        @(negedge clk);
        #1;
        checks++;
        if (err_cnt !== e) begin
            errors++;
            $display("FAIL %s err_cnt=%02h required=%02h", name, err_cnt, e);
        end
    endtask

    task automatic check_empty(input string name);
        @(negedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || rx_char !== 8'h00) begin
            errors++;
            $display("FAIL %s rx_valid=%0b rx_char=%02h required valid=0 char=00",
                     name, rx_valid, rx_char);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        debug_in = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (debug_out.valid !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
            rx_char !== 8'h00 || err_cnt !== 8'h00 || debug_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state out_valid=%0b tx_ready=%0b rx_valid=%0b rx_char=%02h err=%02h in_ready=%0b required 0 1 0 00 00 1",
                     debug_out.valid, tx_ready, rx_valid, rx_char, err_cnt, debug_in_ready);
        end
    endtask

    task automatic test_tx();
        logic [15:0] e [4];
        e[0] = target_id;
        e[1] = id;
        e[2] = 16'h8000;
        e[3] = 16'h0041;
        debug_out_ready = 1'b1;
        @(negedge clk);
        tx_char  = 8'h41;
        tx_valid = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_accept tx_ready=%0b required=1", tx_ready);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (debug_out.valid !== 1'b1 || debug_out.data !== e[k] ||
                debug_out.last !== (k == 3) || tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL tx_flit%0d valid=%0b data=%04h last=%0b tx_ready=%0b required 1 %04h %0b 0",
                         k, debug_out.valid, debug_out.data, debug_out.last, tx_ready, e[k], k == 3);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (tx_ready !== 1'b1 || debug_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_done tx_ready=%0b out_valid=%0b required 1 0", tx_ready, debug_out.valid);
        end
    endtask

    task automatic test_tx_random();
        logic [15:0] e [4];
        logic [7:0]  ch;
        int          got;
        int          cyc;
        bit          ok;
        for (int p = 0; p < 8; p++) begin
            ch   = 8'($urandom);
            e[0] = target_id;
            e[1] = id;
            e[2] = 16'h8000;
            e[3] = {8'h00, ch};
            ok   = 1'b0;
            @(negedge clk);
            tx_char  = ch;
            tx_valid = 1'b1;
            for (int n = 0; n < 50; n++) begin
                #1;
                if (tx_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL tx_rand_accept tx_ready=%0b required=1", tx_ready);
            end
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            got = 0;
            cyc = 0;
            while (got < 4 && cyc < 200) begin
                @(negedge clk);
                debug_out_ready = 1'($urandom_range(0, 1));
                #1;
                if (debug_out.valid === 1'b1 && debug_out_ready) begin
                    checks++;
                    if (debug_out.data !== e[got] || debug_out.last !== (got == 3)) begin
                        errors++;
                        $display("FAIL tx_rand_flit%0d data=%04h last=%0b required %04h %0b",
                                 got, debug_out.data, debug_out.last, e[got], got == 3);
                    end
                    got++;
                end
                cyc++;
            end
            checks++;
            if (got != 4) begin
                errors++;
                $display("FAIL tx_rand_timeout flits=%0d required=4", got);
            end
            @(posedge clk);
            #1;
            debug_out_ready = 1'b1;
        end
    endtask

    task automatic test_rx_basic();
        do_reset();
        set_good(8'h5A);
        send_pkt(4);
        pop_check(8'h5A, "rx_basic_char");
        check_empty("rx_basic_empty");
    endtask

    task automatic test_back_pressure();
        logic [7:0] c [5];
        do_reset();
        for (int i = 0; i < 5; i++) c[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            set_good(c[i]);
            send_pkt(4);
        end
        drive_flit(1'b0, id);
        drive_flit(1'b0, target_id);
        drive_flit(1'b0, 16'h8000);
        @(negedge clk);
        debug_in.valid = 1'b1;
        debug_in.last  = 1'b1;
        debug_in.data  = {8'h00, c[4]};
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (debug_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_low ready=%0b required=0", debug_in_ready);
            end
            @(negedge clk);
        end
        // Pop while full: the stalled DATA flit must still wait this cycle.
        #1;
        checks++;
        if (debug_in_ready !== 1'b0 || rx_char !== c[0]) begin
            errors++;
            $display("FAIL bp_pop_full ready=%0b rx_char=%02h required 0 %02h",
                     debug_in_ready, rx_char, c[0]);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (debug_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_pop ready=%0b required=1", debug_in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        debug_in = '0;
        for (int i = 1; i < 5; i++) pop_check(c[i], "bp_order");
        check_empty("bp_empty");
        check_err(8'h00, "bp_err");
    endtask

    task automatic test_rx_errors();
        logic [7:0] ch;
        do_reset();
        ch = 8'($urandom);
        set_good(8'h11);
        pkt[0] = id + 16'h1;
        send_pkt(4);
        check_err(8'h01, "err_bad_dest");
        set_good(8'h22);
        pkt[2] = 16'h0000;
        send_pkt(4);
        check_err(8'h02, "err_bad_type");
        set_good(8'h33);
        send_pkt(2);
        check_err(8'h03, "err_runt");
        set_good(ch);
        pkt[4] = 16'h1234;
        send_pkt(5);
        check_err(8'h04, "err_long");
        pop_check(ch, "err_long_char");
        check_empty("err_empty");
    endtask

    task automatic test_src_filter();
        do_reset();
        set_good(8'h33);
        pkt[1] = 16'h0007;
        send_pkt(4);
        if (src_filter) begin
            check_empty("src_filter_drop");
            check_err(8'h01, "src_filter_err");
        end else begin
            pop_check(8'h33, "src_open_char");
            check_err(8'h00, "src_open_err");
        end
    endtask

    task automatic test_rx_random();
        int          n;
        int          kind;
        bit          has_char;
        bit          err;
        logic [7:0]  ch;
        logic [1:0]  t;
        logic [3:0]  s;
        do_reset();
        exp_q.delete();
        exp_err  = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 24; p++) begin
                    kind = int'($urandom_range(0, 5));
                    n    = (kind >= 3) ? 4 : int'($urandom_range(1, 6));
                    set_good(8'($urandom));
                    for (int i = 4; i < 8; i++) pkt[i] = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) pkt[1] = 16'h0007;
                    if (kind == 1) pkt[0] = id ^ 16'($urandom_range(1, 65535));
                    if (kind == 2) begin
                        t = 2'($urandom);
                        s = 4'($urandom);
                        if (t == 2'b10 && s == 4'h0) s = 4'h1;
                        pkt[2] = {t, s, 10'h000};
                    end
                    model_pkt(pkt, n, has_char, ch, err);
                    if (has_char) exp_q.push_back(ch);
                    if (err && exp_err < 255) exp_err++;
                    send_pkt(n);
                end
                rnd_done = 1'b1;
            end
            begin
                int cyc;
                logic [7:0] e;
                cyc = 0;
                while (!(rnd_done && exp_q.size() == 0)) begin
                    @(negedge clk);
                    rx_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (rx_valid === 1'b1 && rx_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rx_rand_extra rx_char=%02h required no char", rx_char);
                        end else begin
                            e = exp_q.pop_front();
                            if (rx_char !== e) begin
                                errors++;
                                $display("FAIL rx_rand_char rx_char=%02h required=%02h", rx_char, e);
                            end
                        end
                    end
                    cyc++;
                    if (cyc > 5000) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_rand_timeout pending=%0d required=0", exp_q.size());
                        break;
                    end
                end
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        check_empty("rx_rand_empty");
        check_err(8'(exp_err), "rx_rand_err");
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 254; i++) begin
            pkt[0] = 16'($urandom);
            send_pkt(1);
        end
        check_err(8'hFE, "sat_fe");
        pkt[0] = id;
        send_pkt(1);
        check_err(8'hFF, "sat_ff");
        for (int i = 0; i < 3; i++) begin
            pkt[0] = 16'($urandom);
            send_pkt(1);
        end
        check_err(8'hFF, "sat_hold");
    endtask

    task automatic test_reset_mid_tx();
        do_reset();
        set_good(8'h77);
        send_pkt(4);
        pkt[0] = id;
        send_pkt(1);
        debug_out_ready = 1'b0;
        @(negedge clk);
        tx_char  = 8'h99;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        debug_out_ready = 1'b1;
        @(posedge clk);
        #1;
        debug_out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (debug_out.valid !== 1'b1 || debug_out.data !== id || rx_valid !== 1'b1 || err_cnt !== 8'h01) begin
            errors++;
            $display("FAIL midtx_pre valid=%0b data=%04h rx_valid=%0b err=%02h required 1 %04h 1 01",
                     debug_out.valid, debug_out.data, rx_valid, err_cnt, id);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (debug_out.valid !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL midtx_reset valid=%0b tx_ready=%0b rx_valid=%0b err=%02h required 0 1 0 00",
                     debug_out.valid, tx_ready, rx_valid, err_cnt);
        end
        rst = 1'b0;
        debug_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (debug_out.valid !== 1'b0) begin
                errors++;
                $display("FAIL midtx_no_resume valid=%0b required=0", debug_out.valid);
            end
        end
    endtask

    initial begin
        src_filter = 1'b0;
`ifdef OSD_UART_TERM_SRC_FILTER_EN
        src_filter = 1'b1;
`endif
        rst             = 1'b1;
        debug_in        = '0;
        debug_out_ready = 1'b1;
        rx_ready        = 1'b0;
        tx_char         = 8'h00;
        tx_valid        = 1'b0;
        id              = 16'($urandom_range(16'h0100, 16'h01FF));
        target_id       = 16'($urandom_range(16'h0200, 16'h02FF));

        test_reset();
        test_tx();
        test_tx_random();
        test_rx_basic();
        test_back_pressure();
        test_rx_errors();
        test_src_filter();
        test_rx_random();
        test_err_saturate();
        test_reset_mid_tx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
